// File: rtl/shift_counter_seq_ctrl.sv
// rtl/shift_counter_seq_ctrl.sv - run sequencer for the ring/Johnson counter pair
// Seeds the selected counter, issues nsteps enables, pulses done, traps illegal codes.
module shift_counter_seq_ctrl #(
  parameter int W      = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [STEP_W-1:0] nsteps,
  input  logic [W-1:0]      q_ring,
  input  logic [W-1:0]      q_john,
  output logic              ring_load,
  output logic              john_load,
  output logic              ring_en,
  output logic              john_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  localparam logic [W-1:0]      Q_ONE    = W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t              state, state_nx;
  logic                mode_q;
  logic [STEP_W-1:0]   nsteps_q;
  logic [W-1:0]        q_sel;
  logic                code_ok;
  logic                accept;

  function automatic logic ring_ok(input logic [W-1:0] q);
    return (q != '0) && ((q & (q - Q_ONE)) == '0);
  endfunction

  // A Johnson code is a run of ones anchored at either end: q or ~q is 0..01..1.
  function automatic logic john_ok(input logic [W-1:0] q);
    logic [W-1:0] inv;
    inv = ~q;
    return ((q & (q + Q_ONE)) == '0) || ((inv & (inv + Q_ONE)) == '0);
  endfunction

  always_comb begin
    q_sel   = mode_q ? q_john : q_ring;
    code_ok = mode_q ? john_ok(q_sel) : ring_ok(q_sel);
    accept  = start && (state == IDLE || state == ERR);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR: if (start) state_nx = LOAD;
      LOAD:      state_nx = (nsteps_q == '0) ? DONE : RUN;
      RUN: begin
        if (!code_ok)                              state_nx = ERR;
        else if (step_cnt + STEP_ONE == nsteps_q)  state_nx = DONE;
      end
      DONE:      state_nx = code_ok ? IDLE : ERR;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ring_load = (state == LOAD) && !mode_q;
    john_load = (state == LOAD) &&  mode_q;
    ring_en   = (state == RUN)  && !mode_q;
    john_en   = (state == RUN)  &&  mode_q;
    busy      = (state == LOAD) || (state == RUN);
    done      = (state == DONE);
    err       = (state == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      nsteps_q <= '0;
      step_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mode_q   <= mode;
        nsteps_q <= nsteps;
        step_cnt <= '0;
      end else if (state == RUN) begin
        step_cnt <= step_cnt + STEP_ONE;
      end
    end
  end

endmodule
